// File: rtl/pe_pkg.sv
// Shared constants and FSM state type for the priority-encoder index decoder.
package pe_pkg;
  localparam int PE_WIDTH = 8;
  localparam int PE_IDX_W = 3;
  localparam int PE_CNT_W = 4;

  typedef enum logic {
    ST_EMPTY,
    ST_ACCUM
  } pe_state_e;
endpackage

// File: rtl/pe_index_decoder_if.sv
// Index-beat input stream and rebuilt-mask output stream of the decoder.
interface pe_index_decoder_if
  import pe_pkg::*;
#(
  parameter int WIDTH = PE_WIDTH,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic             in_hit;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_mask;
  logic [CNT_W-1:0] out_count;
  logic             out_dup;
  logic             out_err;

  modport master (
    output in_valid, in_idx, in_hit, in_last, out_ready,
    input  in_ready, out_valid, out_mask, out_count, out_dup, out_err
  );

  modport slave (
    input  in_valid, in_idx, in_hit, in_last, out_ready,
    output in_ready, out_valid, out_mask, out_count, out_dup, out_err
  );
endinterface

// File: rtl/pe_onehot_dec.sv
// Index-to-one-hot decode with range check; empty beats decode to zero.
module pe_onehot_dec
  import pe_pkg::*;
#(
  parameter int WIDTH = PE_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             hit,
  output logic [WIDTH-1:0] oh,
  output logic             err
);
  // One extra bit so a non-power-of-two WIDTH fits in the compare.
  localparam logic [IDX_W:0] WIDTH_L = (IDX_W + 1)'(WIDTH);

  logic in_range;

  always_comb begin
    in_range = {1'b0, idx} < WIDTH_L;
    oh       = (hit && in_range) ? (WIDTH'(1) << idx) : '0;
    err      = hit && !in_range;
  end
endmodule

// File: rtl/pe_index_decoder.sv
// Rebuilds request bitmasks from a stream of encoded bit positions.
//
// state    | meaning
// ST_EMPTY | no beat of the current group accepted yet
// ST_ACCUM | at least one non-last beat of the current group accepted
module pe_index_decoder
  import pe_pkg::*;
#(
  parameter int WIDTH = PE_WIDTH,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic               clk,
  input logic               rst_n,
  pe_index_decoder_if.slave bus
);
  pe_state_e        state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, acc_n;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n;
  logic             dupf_q, dupf_d, dupf_n;
  logic             errf_q, errf_d, errf_n;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_mask_q, out_mask_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_dup_q, out_dup_d;
  logic             out_err_q, out_err_d;

  logic [WIDTH-1:0] oh;
  logic             err_b;
  logic             dup_b;
  logic             new_bit;
  logic             accept;

  pe_onehot_dec #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_dec (
    .idx (bus.in_idx),
    .hit (bus.in_hit),
    .oh  (oh),
    .err (err_b)
  );

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_mask  = out_mask_q;
  assign bus.out_count = out_count_q;
  assign bus.out_dup   = out_dup_q;
  assign bus.out_err   = out_err_q;

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    dup_b   = |(acc_q & oh);
    new_bit = (|oh) && !dup_b;
    acc_n   = acc_q | oh;
    cnt_n   = cnt_q + CNT_W'(new_bit);
    dupf_n  = dupf_q | dup_b;
    errf_n  = errf_q | err_b;

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    dupf_d      = dupf_q;
    errf_d      = errf_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_mask_d  = out_mask_q;
    out_count_d = out_count_q;
    out_dup_d   = out_dup_q;
    out_err_d   = out_err_q;

    if (accept) begin
      if (bus.in_last) begin
        // A last beat may land in the same cycle the previous group drains.
        out_valid_d = 1'b1;
        out_mask_d  = acc_n;
        out_count_d = cnt_n;
        out_dup_d   = dupf_n;
        out_err_d   = errf_n;
        acc_d       = '0;
        cnt_d       = '0;
        dupf_d      = 1'b0;
        errf_d      = 1'b0;
        state_d     = ST_EMPTY;
      end else begin
        acc_d   = acc_n;
        cnt_d   = cnt_n;
        dupf_d  = dupf_n;
        errf_d  = errf_n;
        state_d = ST_ACCUM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      acc_q       <= '0;
      cnt_q       <= '0;
      dupf_q      <= 1'b0;
      errf_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_mask_q  <= '0;
      out_count_q <= '0;
      out_dup_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dupf_q      <= dupf_d;
      errf_q      <= errf_d;
      out_valid_q <= out_valid_d;
      out_mask_q  <= out_mask_d;
      out_count_q <= out_count_d;
      out_dup_q   <= out_dup_d;
      out_err_q   <= out_err_d;
    end
  end
endmodule

// File: tb/tb_pe_index_decoder.sv
// Directed bench for pe_index_decoder: inputs change and outputs are sampled on the falling edge.
module tb_pe_index_decoder;
  import pe_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  pe_index_decoder_if bus ();

  pe_index_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] m,
                         input logic [3:0] c, input logic d, input logic e);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, ".mask"},  32'(bus.out_mask),  32'(m));
    chk({tag, ".count"}, 32'(bus.out_count), 32'(c));
    chk({tag, ".dup"},   32'(bus.out_dup),   32'(d));
    chk({tag, ".err"},   32'(bus.out_err),   32'(e));
  endtask

  // Present one beat, confirm it can be taken, and let one edge accept it.
  task automatic beat(input string tag, input logic [2:0] idx, input logic hit, input logic last);
    bus.in_valid = 1'b1;
    bus.in_idx   = idx;
    bus.in_hit   = hit;
    bus.in_last  = last;
    #1;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    tests        = 0;
    failed       = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_idx   = '0;
    bus.in_hit   = 1'b0;
    bus.in_last  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_out("reset", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // One-beat group.
    beat("g1", 3'd5, 1'b1, 1'b1);
    chk_out("g1", 1'b1, 8'h20, 4'd1, 1'b0, 1'b0);
    @(negedge clk);
    chk("g1.drain", 32'(bus.out_valid), 32'd0);
    chk("g1.hold", 32'(bus.out_mask), 32'h20);

    // Back-to-back beats at full throughput.
    beat("g2a", 3'd0, 1'b1, 1'b0);
    beat("g2b", 3'd3, 1'b1, 1'b0);
    beat("g2c", 3'd7, 1'b1, 1'b1);
    chk_out("g2", 1'b1, 8'h89, 4'd3, 1'b0, 1'b0);

    // Repeated index is flagged but counted once.
    beat("g3a", 3'd2, 1'b1, 1'b0);
    beat("g3b", 3'd2, 1'b1, 1'b0);
    beat("g3c", 3'd4, 1'b1, 1'b1);
    chk_out("g3", 1'b1, 8'h14, 4'd2, 1'b1, 1'b0);

    // Empty group; flags must not leak from the previous group.
    beat("g4a", 3'd6, 1'b0, 1'b0);
    beat("g4b", 3'd1, 1'b0, 1'b1);
    chk_out("g4", 1'b1, 8'h00, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("g4.pulse", 32'(bus.out_valid), 32'd0);

    // Every bit set: count reaches WIDTH.
    for (int i = 0; i < 8; i++) beat("g5", 3'(i), 1'b1, i == 7);
    chk_out("g5", 1'b1, 8'hFF, 4'd8, 1'b0, 1'b0);
    @(negedge clk);

    // Backpressure, then a new last beat in the cycle the consumer returns.
    bus.out_ready = 1'b0;
    beat("g6", 3'd1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_idx   = 3'd3;
      bus.in_hit   = 1'b1;
      bus.in_last  = 1'b0;
      #1;
      chk("g6.stall_ready", 32'(bus.in_ready), 32'd0);
      chk_out("g6.stall", 1'b1, 8'h02, 4'd1, 1'b0, 1'b0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    beat("g7", 3'd6, 1'b1, 1'b1);
    chk_out("g7", 1'b1, 8'h40, 4'd1, 1'b0, 1'b0);
    @(negedge clk);
    chk("g7.drain", 32'(bus.out_valid), 32'd0);
    chk("g7.hold", 32'(bus.out_mask), 32'h40);

    // Reset mid-group discards the partial accumulation.
    beat("g8a", 3'd1, 1'b1, 1'b0);
    beat("g8b", 3'd6, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_out("g8.reset", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    beat("g8c", 3'd0, 1'b1, 1'b1);
    chk_out("g8", 1'b1, 8'h01, 4'd1, 1'b0, 1'b0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/pe_index_decoder.md
Name: pe_index_decoder

Overview:
- Inverse of the team's 8-to-3 priority encoder.
- Accepts a stream of encoded bit positions (index plus a valid/empty qualifier) over a valid/ready handshake and decodes each beat to one-hot.
- ORs the decoded beats into an accumulated bitmask; on the beat flagged last, emits the rebuilt mask with population count and error flags through a one-entry registered output stage.
- Sits downstream of priority-encoder result streams; used to reconstruct request vectors.

Parameters:
- WIDTH, 8, number of mask bits; must be >= 2.
- IDX_W, $clog2(WIDTH) (3 at default), width of the index field.
- CNT_W, $clog2(WIDTH+1) (4 at default), width of the population count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept a beat.
- in_idx  input  IDX_W  encoded bit position.
- in_hit  input  1  1 = in_idx is meaningful; 0 = encoder reported no bit set (empty beat).
- in_last  input  1  final beat of the current group.
- out_valid  output  1  out_* fields hold a completed group.
- out_ready  input  1  consumer accepts the group.
- out_mask  output  WIDTH  rebuilt bitmask.
- out_count  output  CNT_W  number of distinct bits set in out_mask.
- out_dup  output  1  at least one hit beat repeated an index already in the group.
- out_err  output  1  at least one hit beat had in_idx >= WIDTH.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on rst_n. All state is sampled on the rising edge of clk.
- Reset: out_valid=0, out_mask=0, out_count=0, out_dup=0, out_err=0, accumulator cleared, FSM to EMPTY. Reset mid-group discards the partial group and any unconsumed output.
- Handshakes:
  - in_ready = !out_valid || out_ready (combinational; allows full throughput).
  - An input beat is accepted when in_valid && in_ready.
  - Output is consumed when out_valid && out_ready.
- Decode per accepted beat:
  - oh = (in_hit && in_idx < WIDTH) ? (1 << in_idx) : 0.
  - dup_b = |(acc & oh).
  - err_b = in_hit && in_idx >= WIDTH.
  - acc_n = acc | oh; cnt_n = cnt + (oh != 0 && !dup_b); dupf_n = dupf | dup_b; errf_n = errf | err_b.
  - in_idx is ignored when in_hit=0.
- FSM, two states:
  - EMPTY: no beats accepted for the current group.
  - ACCUM: at least one non-last beat accepted.
  - Accepted beat with in_last=0: move to / stay in ACCUM; store acc_n, cnt_n, dupf_n, errf_n.
  - Accepted beat with in_last=1: load out_* from the _n values; set out_valid=1; clear acc, cnt and flags; go to EMPTY.
  - A single beat with in_last=1 in EMPTY is a complete one-beat group.
- Latency: out_valid asserts the cycle after the last beat is accepted.
- Output stage:
  - out_* are stable while out_valid=1 && out_ready=0.
  - Output consume with no new last in the same cycle: out_valid falls to 0; out_* hold their values.
  - Output consume and a last beat in the same cycle: out_* reload with the new group and out_valid stays 1.
- Backpressure: when out_valid=1 && out_ready=0, in_ready=0 and the accumulator freezes.
- Empty group (all beats in_hit=0): out_mask=0, out_count=0, flags 0.
- Saturation is impossible: cnt counts only distinct set bits, so cnt <= WIDTH.

Decomposition:
- Shared package pe_pkg: localparams PE_WIDTH=8, PE_IDX_W=3, PE_CNT_W=4; FSM state enum {ST_EMPTY, ST_ACCUM}.
- One natural sub-module, pe_onehot_dec: combinational index-to-one-hot with range check (outputs oh, err). The rest is a single always_ff plus next-state logic.

Test Plan:
- Reset, then single beat idx=5 hit=1 last=1 -> next cycle out_valid=1, out_mask=0x20, out_count=1, out_dup=0, out_err=0.
- Beats idx 0,3,7, last on 7, out_ready=1 -> out_mask=0x89, out_count=3; in_ready stays 1 for all beats.
- Beats idx 2,2,4 (last) -> out_mask=0x14, out_count=2, out_dup=1.
- Beats hit=0,hit=0(last) -> out_mask=0x00, out_count=0, out_valid pulses 1 cycle.
- Hold out_ready=0 for 4 cycles after a group -> in_ready=0, out_* stable; drop a new last beat in the same cycle out_ready rises -> out_valid stays 1 and out_* update next cycle.
- Assert rst_n=0 for one cycle after 2 non-last beats (idx 1,6), then send idx 0 last -> out_mask=0x01, out_count=1.
